// File: rtl/neuron_rnl_tnn.sv
// neuron_rnl_tnn
// Self-contained SRM0 neuron with a ramp-no-leak (RNL) response. Each
// synapse stores a weight that the column can nudge with STDP inc/dec
// strobes. A rising edge on a synapse input starts a ramp that adds one
// unit to the body potential per cycle, for as many cycles as the weight
// captured at that edge. The neuron fires once per gamma wave when the
// potential crosses THRESHOLD, unless WTA inhibit locks it out first.
//
// Ports:
//   clk           unit clock
//   rst           asynchronous active-high reset
//   grst          1-cycle gamma pulse, starts a new wave
//   input_spikes  temporally coded input pulses, one bit per synapse
//   w_load        load all weights from w_init
//   w_init        weight load value, synapse i at [i*WRES +: WRES]
//   inc / dec     per-synapse saturating STDP increment / decrement
//   inhibit       WTA inhibit; suppresses a fire and locks the wave
//   output_spike  output pulse (WMAX+1 cycles or 1 cycle, see PULSE_MODE)
//   spike_time    gamma-counter value at the fire
//   spike_valid   high from fire until the next grst
//   weights       current synaptic weights, same packing as w_init
//   potential     saturating body potential
module neuron_rnl_tnn #(
    parameter int INP        = 4,
    parameter int WRES       = 3,
    parameter int THRESHOLD  = 13,
    parameter int TW         = 4,
    parameter int PULSE_MODE = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    grst,
    input  logic [INP-1:0]                          input_spikes,
    input  logic                                    w_load,
    input  logic [INP*WRES-1:0]                     w_init,
    input  logic [INP-1:0]                          inc,
    input  logic [INP-1:0]                          dec,
    input  logic                                    inhibit,
    output logic                                    output_spike,
    output logic [TW-1:0]                           spike_time,
    output logic                                    spike_valid,
    output logic [INP*WRES-1:0]                     weights,
    output logic [$clog2(INP*(2**WRES-1)+1)-1:0]    potential
);

    localparam int WMAX = 2**WRES - 1;
    localparam int PMAX = INP * WMAX;
    localparam int POTW = $clog2(PMAX + 1);
    // Sum width leaves headroom for one cycle of full contributions.
    localparam int SUMW = $clog2(PMAX + INP + 1);

    generate
        if (THRESHOLD < 1 || THRESHOLD > PMAX) begin : g_threshold_check
            $error("neuron_rnl_tnn: THRESHOLD must lie in 1..INP*WMAX");
        end
    endgenerate

    // State
    logic [INP-1:0][WRES-1:0] w_q;
    logic [INP-1:0][WRES-1:0] rem_q;
    logic [INP-1:0]           prev_q;
    logic [INP-1:0]           seen_q;
    logic [POTW-1:0]          potential_q;
    logic                     fired_q;
    logic                     locked_q;
    logic [TW-1:0]            gamma_q;
    logic                     out_q;
    logic [WRES-1:0]          pcnt_q;
    logic [TW-1:0]            time_q;
    logic                     valid_q;

    // Combinational next-state helpers
    logic [INP-1:0]           edge_det;
    logic [INP-1:0]           accept;
    logic [INP-1:0]           contrib;
    logic [SUMW-1:0]          add_cnt;
    logic [SUMW-1:0]          sum;
    logic [POTW-1:0]          pot_next;
    logic [TW-1:0]            gamma_next;
    logic                     fire_ok;

    always_comb begin
        edge_det = input_spikes & ~prev_q;
        // Only the first edge of a wave on each synapse is accepted.
        accept   = edge_det & ~seen_q;
        contrib  = '0;
        add_cnt  = '0;
        for (int unsigned i = 0; i < INP; i++) begin
            contrib[i] = (accept[i] && (w_q[i] != '0)) || (rem_q[i] != '0);
            add_cnt    = add_cnt + SUMW'(contrib[i]);
        end
        sum      = SUMW'(potential_q) + add_cnt;
        pot_next = (sum > SUMW'(PMAX)) ? POTW'(PMAX) : sum[POTW-1:0];

        if (grst)
            gamma_next = '0;
        else if (gamma_q == '1)
            gamma_next = gamma_q;
        else
            gamma_next = gamma_q + TW'(1);

        fire_ok = (pot_next >= POTW'(THRESHOLD)) && !fired_q && !locked_q && !grst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q         <= '0;
            rem_q       <= '0;
            prev_q      <= '0;
            seen_q      <= '0;
            potential_q <= '0;
            fired_q     <= 1'b0;
            locked_q    <= 1'b0;
            gamma_q     <= '0;
            out_q       <= 1'b0;
            pcnt_q      <= '0;
            time_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            // prev tracks the raw input even across grst, so a pulse that
            // spans the gamma boundary produces no edge in the new wave.
            prev_q  <= input_spikes;
            gamma_q <= gamma_next;

            for (int unsigned i = 0; i < INP; i++) begin
                if (w_load)
                    w_q[i] <= w_init[i*WRES +: WRES];
                else if (inc[i] && !dec[i]) begin
                    if (w_q[i] != WRES'(WMAX))
                        w_q[i] <= w_q[i] + WRES'(1);
                end else if (dec[i] && !inc[i]) begin
                    if (w_q[i] != '0)
                        w_q[i] <= w_q[i] - WRES'(1);
                end
            end

            if (grst) begin
                potential_q <= '0;
                rem_q       <= '0;
                seen_q      <= '0;
                fired_q     <= 1'b0;
                locked_q    <= 1'b0;
                out_q       <= 1'b0;
                pcnt_q      <= '0;
                valid_q     <= 1'b0;
            end else begin
                potential_q <= pot_next;
                seen_q      <= seen_q | accept;

                // The edge cycle itself contributes one unit, so the
                // counter is loaded with w-1 remaining cycles.
                for (int unsigned i = 0; i < INP; i++) begin
                    if (accept[i])
                        rem_q[i] <= (w_q[i] != '0) ? (w_q[i] - WRES'(1)) : '0;
                    else if (rem_q[i] != '0)
                        rem_q[i] <= rem_q[i] - WRES'(1);
                end

                if (out_q) begin
                    if (pcnt_q == '0)
                        out_q <= 1'b0;
                    else
                        pcnt_q <= pcnt_q - WRES'(1);
                end

                if (fire_ok) begin
                    if (inhibit)
                        locked_q <= 1'b1;
                    else begin
                        fired_q <= 1'b1;
                        out_q   <= 1'b1;
                        time_q  <= gamma_next;
                        valid_q <= 1'b1;
                        pcnt_q  <= (PULSE_MODE != 0) ? WRES'(WMAX) : '0;
                    end
                end
            end
        end
    end

    assign weights      = w_q;
    assign potential    = potential_q;
    assign output_spike = out_q;
    assign spike_time   = time_q;
    assign spike_valid  = valid_q;

endmodule

// File: tb/tb_neuron_rnl_tnn.sv
// Directed self-checking bench for neuron_rnl_tnn (INP=4, WRES=3,
// THRESHOLD=13, TW=4). A second instance built with PULSE_MODE=0 shares
// the inputs and is used to check the single-cycle output pulse.
module tb_neuron_rnl_tnn;

    logic        clk;
    logic        rst;
    logic        grst;
    logic [3:0]  input_spikes;
    logic        w_load;
    logic [11:0] w_init;
    logic [3:0]  inc;
    logic [3:0]  dec;
    logic        inhibit;

    logic        output_spike;
    logic [3:0]  spike_time;
    logic        spike_valid;
    logic [11:0] weights;
    logic [4:0]  potential;

    logic        p0_spike;
    logic [3:0]  p0_time;
    logic        p0_valid;
    logic [11:0] p0_weights;
    logic [4:0]  p0_potential;

    int n_cmp;
    int n_err;

    neuron_rnl_tnn #(.INP(4), .WRES(3), .THRESHOLD(13), .TW(4), .PULSE_MODE(1)) dut (
        .clk(clk), .rst(rst), .grst(grst), .input_spikes(input_spikes),
        .w_load(w_load), .w_init(w_init), .inc(inc), .dec(dec), .inhibit(inhibit),
        .output_spike(output_spike), .spike_time(spike_time), .spike_valid(spike_valid),
        .weights(weights), .potential(potential)
    );

    neuron_rnl_tnn #(.INP(4), .WRES(3), .THRESHOLD(13), .TW(4), .PULSE_MODE(0)) dut_p0 (
        .clk(clk), .rst(rst), .grst(grst), .input_spikes(input_spikes),
        .w_load(w_load), .w_init(w_init), .inc(inc), .dec(dec), .inhibit(inhibit),
        .output_spike(p0_spike), .spike_time(p0_time), .spike_valid(p0_valid),
        .weights(p0_weights), .potential(p0_potential)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input logic [11:0] v);
        w_init = v;
        w_load = 1'b1;
        tick();
        w_load = 1'b0;
    endtask

    task automatic start_wave();
        grst = 1'b1;
        tick();
        grst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; grst = 1'b0; input_spikes = '0; w_load = 1'b0;
        w_init = '0; inc = '0; dec = '0; inhibit = 1'b0;
        #12;
        n_cmp++; if (potential !== 5'd0) begin n_err++; $display("FAIL reset_pot: got %0d expected 0", potential); end
        n_cmp++; if (weights !== 12'd0) begin n_err++; $display("FAIL reset_weights: got %h expected 000", weights); end
        n_cmp++; if (output_spike !== 1'b0 || spike_valid !== 1'b0 || spike_time !== 4'd0) begin
            n_err++; $display("FAIL reset_out: got spike=%b valid=%b time=%0d expected 0/0/0", output_spike, spike_valid, spike_time);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_fire();
        int width;
        load_weights(12'o7777);
        n_cmp++; if (weights !== 12'o7777) begin n_err++; $display("FAIL basic_wload: got %o expected 7777", weights); end
        start_wave();
        input_spikes = 4'hF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++; if (potential !== 5'(4*k)) begin n_err++; $display("FAIL basic_pot P%0d: got %0d expected %0d", k, potential, 4*k); end
            if (k < 4) begin
                n_cmp++; if (output_spike !== 1'b0) begin n_err++; $display("FAIL basic_early P%0d: got %b expected 0", k, output_spike); end
            end
        end
        n_cmp++; if (output_spike !== 1'b1) begin n_err++; $display("FAIL basic_fire: got %b expected 1", output_spike); end
        n_cmp++; if (spike_time !== 4'd4) begin n_err++; $display("FAIL basic_time: got %0d expected 4", spike_time); end
        n_cmp++; if (spike_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", spike_valid); end
        width = 1;
        for (int k = 5; k <= 14; k++) begin
            tick();
            if (k == 8) input_spikes = '0;
            if (output_spike === 1'b1) width++;
        end
        n_cmp++; if (width != 8) begin n_err++; $display("FAIL basic_width: got %0d expected 8", width); end
        n_cmp++; if (potential !== 5'd28) begin n_err++; $display("FAIL basic_sat: got %0d expected 28", potential); end
        n_cmp++; if (spike_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_hold: got %b expected 1", spike_valid); end
    endtask

    task automatic test_sub_threshold();
        int highs;
        load_weights(12'o3333);
        start_wave();
        input_spikes = 4'hF;
        highs = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 8) input_spikes = '0;
            if (output_spike === 1'b1) highs++;
            if (k == 3) begin
                n_cmp++; if (potential !== 5'd12) begin n_err++; $display("FAIL sub_pot_P3: got %0d expected 12", potential); end
            end
        end
        n_cmp++; if (potential !== 5'd12) begin n_err++; $display("FAIL sub_pot_hold: got %0d expected 12", potential); end
        n_cmp++; if (highs != 0) begin n_err++; $display("FAIL sub_nospike: got %0d high cycles expected 0", highs); end
        n_cmp++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL sub_valid: got %b expected 0", spike_valid); end
    endtask

    task automatic test_staggered();
        int exp_pot [11] = '{1, 2, 4, 6, 8, 10, 12, 13, 14, 14, 14};
        load_weights(12'o0077);
        start_wave();
        for (int k = 1; k <= 11; k++) begin
            input_spikes[0] = (k <= 8);
            input_spikes[1] = (k >= 3 && k <= 10);
            tick();
            n_cmp++; if (potential !== 5'(exp_pot[k-1])) begin n_err++; $display("FAIL stag_pot P%0d: got %0d expected %0d", k, potential, exp_pot[k-1]); end
            n_cmp++; if (output_spike !== 1'(k >= 8)) begin n_err++; $display("FAIL stag_spike P%0d: got %b expected %b", k, output_spike, (k >= 8)); end
        end
        input_spikes = '0;
        n_cmp++; if (spike_time !== 4'd8) begin n_err++; $display("FAIL stag_time: got %0d expected 8", spike_time); end
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_inhibit();
        load_weights(12'o7777);
        start_wave();
        input_spikes = 4'hF;
        for (int k = 1; k <= 3; k++) tick();
        inhibit = 1'b1;
        tick();
        inhibit = 1'b0;
        n_cmp++; if (output_spike !== 1'b0 || spike_valid !== 1'b0) begin n_err++; $display("FAIL inh_P4: got spike=%b valid=%b expected 0/0", output_spike, spike_valid); end
        tick();
        n_cmp++; if (output_spike !== 1'b0) begin n_err++; $display("FAIL inh_locked_P5: got %b expected 0", output_spike); end
        n_cmp++; if (potential !== 5'd20) begin n_err++; $display("FAIL inh_pot_P5: got %0d expected 20", potential); end
        for (int k = 6; k <= 8; k++) tick();
        input_spikes = '0;
        tick();
        start_wave();
        input_spikes = 4'hF;
        for (int k = 1; k <= 4; k++) tick();
        n_cmp++; if (output_spike !== 1'b1 || spike_time !== 4'd4) begin n_err++; $display("FAIL inh_next_wave: got spike=%b time=%0d expected 1/4", output_spike, spike_time); end
        for (int k = 5; k <= 12; k++) begin
            tick();
            if (k == 8) input_spikes = '0;
        end
    endtask

    task automatic test_stdp();
        load_weights(12'o2507);
        inc = 4'b1101;
        dec = 4'b0110;
        tick();
        n_cmp++; if (weights !== 12'o3507) begin n_err++; $display("FAIL stdp_sat: got %o expected 3507", weights); end
        inc = 4'b0000;
        dec = 4'b0001;
        tick();
        n_cmp++; if (weights !== 12'o3506) begin n_err++; $display("FAIL stdp_dec: got %o expected 3506", weights); end
        inc = 4'b1111;
        dec = 4'b0000;
        load_weights(12'o0123);
        inc = '0;
        n_cmp++; if (weights !== 12'o0123) begin n_err++; $display("FAIL stdp_wload_prio: got %o expected 0123", weights); end
    endtask

    task automatic test_second_pulse();
        load_weights(12'o0003);
        start_wave();
        input_spikes = 4'b0001;
        tick();
        // Raise the weight mid-ramp; the ramp keeps the captured value.
        w_init = 12'o0007;
        w_load = 1'b1;
        tick();
        w_load = 1'b0;
        tick();
        n_cmp++; if (potential !== 5'd3) begin n_err++; $display("FAIL pulse2_first: got %0d expected 3", potential); end
        input_spikes = '0;
        tick();
        input_spikes = 4'b0001;
        for (int k = 5; k <= 9; k++) tick();
        input_spikes = '0;
        n_cmp++; if (potential !== 5'd3) begin n_err++; $display("FAIL pulse2_ignored: got %0d expected 3", potential); end
        n_cmp++; if (weights !== 12'o0007) begin n_err++; $display("FAIL pulse2_weight: got %o expected 0007", weights); end
    endtask

    task automatic test_grst_truncate();
        load_weights(12'o7777);
        start_wave();
        input_spikes = 4'hF;
        for (int k = 1; k <= 5; k++) tick();
        n_cmp++; if (output_spike !== 1'b1) begin n_err++; $display("FAIL trunc_pre: got %b expected 1", output_spike); end
        grst = 1'b1;
        tick();
        grst = 1'b0;
        n_cmp++; if (output_spike !== 1'b0 || spike_valid !== 1'b0) begin n_err++; $display("FAIL trunc_drop: got spike=%b valid=%b expected 0/0", output_spike, spike_valid); end
        n_cmp++; if (potential !== 5'd0) begin n_err++; $display("FAIL trunc_pot: got %0d expected 0", potential); end
        tick(); tick();
        input_spikes = '0;
        tick(); tick();
        n_cmp++; if (potential !== 5'd0 || output_spike !== 1'b0) begin n_err++; $display("FAIL trunc_span: got pot=%0d spike=%b expected 0/0", potential, output_spike); end
    endtask

    task automatic test_gamma_sat();
        load_weights(12'o7777);
        start_wave();
        for (int k = 1; k <= 16; k++) tick();
        input_spikes = 4'hF;
        for (int k = 1; k <= 4; k++) tick();
        n_cmp++; if (output_spike !== 1'b1 || spike_time !== 4'd15) begin n_err++; $display("FAIL gamma_sat: got spike=%b time=%0d expected 1/15", output_spike, spike_time); end
        for (int k = 5; k <= 12; k++) begin
            tick();
            if (k == 8) input_spikes = '0;
        end
    endtask

    task automatic test_pulse_mode0();
        int highs;
        load_weights(12'o7777);
        start_wave();
        input_spikes = 4'hF;
        for (int k = 1; k <= 4; k++) tick();
        n_cmp++; if (p0_spike !== 1'b1 || p0_time !== 4'd4) begin n_err++; $display("FAIL pm0_fire: got spike=%b time=%0d expected 1/4", p0_spike, p0_time); end
        tick();
        n_cmp++; if (p0_spike !== 1'b0 || output_spike !== 1'b1) begin n_err++; $display("FAIL pm0_width: got pm0=%b pm1=%b expected 0/1", p0_spike, output_spike); end
        highs = 0;
        for (int k = 6; k <= 13; k++) begin
            tick();
            if (k == 8) input_spikes = '0;
            if (p0_spike === 1'b1) highs++;
        end
        n_cmp++; if (highs != 0 || p0_valid !== 1'b1) begin n_err++; $display("FAIL pm0_after: got highs=%0d valid=%b expected 0/1", highs, p0_valid); end
    endtask

    task automatic test_async_rst();
        load_weights(12'o7777);
        start_wave();
        input_spikes = 4'hF;
        for (int k = 1; k <= 5; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (potential !== 5'd0 || weights !== 12'd0) begin n_err++; $display("FAIL arst_state: got pot=%0d w=%o expected 0/0", potential, weights); end
        n_cmp++; if (output_spike !== 1'b0 || spike_valid !== 1'b0 || spike_time !== 4'd0) begin
            n_err++; $display("FAIL arst_out: got spike=%b valid=%b time=%0d expected 0/0/0", output_spike, spike_valid, spike_time);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        n_cmp++; if (potential !== 5'd0 || output_spike !== 1'b0) begin n_err++; $display("FAIL arst_release: got pot=%0d spike=%b expected 0/0", potential, output_spike); end
        input_spikes = '0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic_fire();
        test_sub_threshold();
        test_staggered();
        test_inhibit();
        test_stdp();
        test_second_pulse();
        test_grst_truncate();
        test_gamma_sat();
        test_pulse_mode0();
        test_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
